xmem_pair_sched: RTL
====================

Name: xmem_pair_sched

Overview:
- Controller for the 256x32 dual-port point memory in the k-furthest-neighbors datapath.
- LOAD phase: accepts N 32-bit point words from a valid/ready stream and writes them to addresses 0..N-1 through port 0.
- PAIR phase: issues one dual-port read per cycle for every unordered pair (i, j), i<j, then presents both words to the distance pipeline over a valid/ready output.
- Only master of the memory pins; sits between the point loader and the distance/top-K logic.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, point word width.
- DEPTH, 256, memory depth (2**ADDR_W).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- num_pts  input  ADDR_W+1  point count N (0..DEPTH); latched on accepted start.
- in_data  input  DATA_W  point word to load.
- in_valid  input  1  in_data valid.
- in_ready  output  1  high only in LOAD.
- out_i  output  ADDR_W  index of first point of pair.
- out_j  output  ADDR_W  index of second point of pair.
- out_q0  output  DATA_W  word at out_i (combinational pass of mem_q0).
- out_q1  output  DATA_W  word at out_j (combinational pass of mem_q1).
- out_valid  output  1  pair valid.
- out_ready  input  1  consumer accepts pair.
- busy  output  1  high in LOAD or PAIR.
- done  output  1  one-cycle pulse at end of run.
- mem_cen0, mem_wen0  output  1 each  port-0 chip enable / write enable, active-low.
- mem_a0  output  ADDR_W  port-0 address.
- mem_d0  output  DATA_W  port-0 write data.
- mem_cen1, mem_wen1  output  1 each  port-1 enables, active-low.
- mem_a1  output  ADDR_W  port-1 address.
- mem_d1  output  DATA_W  tied 0; port 1 never writes.
- mem_q0, mem_q1  input  DATA_W  memory read data, valid the cycle after the read is issued.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RESET. Reset is honoured in any state, including mid-run.
- Reset values:
  - state IDLE; busy, done, in_ready, out_valid all 0.
  - mem_cen0/1 = 1, mem_wen0/1 = 1, mem_a0/1 = 0, mem_d0 = 0.
  - out_i/out_j = 0; all counters 0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD, PAIR, DONE.
- IDLE:
  - start=1 latches N and goes to LOAD.
  - If N=0, goes directly to DONE.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, same cycle: mem_cen0=0, mem_wen0=0, mem_a0=load_cnt, mem_d0=in_data; load_cnt increments.
  - Port 1 stays disabled.
  - After the N-th write, goes to PAIR. If N=1, goes to DONE instead.
- PAIR read issue:
  - A read is issued when pairs remain and (!out_valid || out_ready).
  - Issue drives mem_cen0=mem_cen1=0, mem_wen0=mem_wen1=1, mem_a0=i, mem_a1=j.
  - i and j are registered into out_i/out_j; out_valid=1 next cycle.
- PAIR stall: with out_valid=1 and out_ready=0, no read is issued (CEN high). The memory's registered address holds, so out_q0/out_q1 stay stable.
- PAIR throughput: one pair per cycle with out_ready held high. Latency from issue to out_valid is 1 cycle.
- Pair order:
  - i=0..N-2, j=i+1..N-1.
  - After j=N-1 the next pair is i+1, j=i+2.
  - Total N(N-1)/2 pairs.
- PAIR exit: out_valid drops after the last pair is accepted if no further read is issued. Goes to DONE on the handshake of the final pair.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Boundaries:
  - start is ignored while busy.
  - N=DEPTH: load_cnt and i/j use ADDR_W+1-bit counters, so index 255 is reached without wrap.
  - in_valid outside LOAD is ignored.
  - Never issues a read and a write in the same cycle.

Optional Feature:
- Macro: XMEM_SELF_PAIR_EN.
- Defined: j starts at i (self pairs included). Order is i=0..N-1, j=i..N-1; total N(N+1)/2 pairs. N=1 goes LOAD→PAIR and emits the single pair (0,0).
- Undefined: behaviour as above, i<j only.

Test Plan:
- Load and stream, no stalls: N=4, words 0x10,0x20,0x30,0x40 with in_valid continuous, out_ready=1.
  - Expect 4 port-0 writes to addresses 0..3.
  - Then 6 pairs on consecutive cycles: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3), with out_q0/out_q1 matching the stored words.
  - done pulses 1 cycle after the last accept.
- Backpressure: N=3, out_ready toggles 1,0,0,1,…
  - Pairs (0,1),(0,2),(1,2) each delivered exactly once.
  - No read issued while stalled.
  - out_q0/out_q1 stable during stall cycles.
- Degenerate counts:
  - N=0: done one cycle after start, no memory access.
  - N=1: one write, then done, no reads (with XMEM_SELF_PAIR_EN: one pair (0,0)).
- Full depth: N=256, word k = k.
  - 32640 pairs.
  - Last pair is (254,255) with data 0xFE/0xFF.
  - No index wrap.
- Reset mid-PAIR: assert RESET during the 3rd pair of N=4.
  - Next cycle: IDLE, out_valid=0, mem_cen0/1=1, busy=0.
  - A new start with N=2 yields the single pair (0,1).
- start while busy: pulse start with N=5 during LOAD of an N=3 run; it is ignored and the run completes with 3 pairs.

Source files
------------

// File: rtl/xmem_pair_sched_if.sv
// xmem_pair_sched_if: bundles the point-load stream, the pair output stream and the dual-port memory pins.
// Signal groups:
//   in_data/in_valid/in_ready                    point words from the loader
//   out_i/out_j/out_q0/out_q1/out_valid/out_ready pairs to the distance pipeline
//   mem_cen*/mem_wen*/mem_a*/mem_d*/mem_q*       256x32 dual-port memory, active-low enables
// Modports: master = scheduler, slave = loader/consumer/memory environment.
interface xmem_pair_sched_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] out_i;
    logic [ADDR_W-1:0] out_j;
    logic [DATA_W-1:0] out_q0;
    logic [DATA_W-1:0] out_q1;
    logic              out_valid;
    logic              out_ready;
    logic              mem_cen0;
    logic              mem_wen0;
    logic [ADDR_W-1:0] mem_a0;
    logic [DATA_W-1:0] mem_d0;
    logic              mem_cen1;
    logic              mem_wen1;
    logic [ADDR_W-1:0] mem_a1;
    logic [DATA_W-1:0] mem_d1;
    logic [DATA_W-1:0] mem_q0;
    logic [DATA_W-1:0] mem_q1;

    modport master (
        input  in_data, in_valid, out_ready, mem_q0, mem_q1,
        output in_ready, out_i, out_j, out_q0, out_q1, out_valid,
               mem_cen0, mem_wen0, mem_a0, mem_d0, mem_cen1, mem_wen1, mem_a1, mem_d1
    );

    modport slave (
        output in_data, in_valid, out_ready, mem_q0, mem_q1,
        input  in_ready, out_i, out_j, out_q0, out_q1, out_valid,
               mem_cen0, mem_wen0, mem_a0, mem_d0, mem_cen1, mem_wen1, mem_a1, mem_d1
    );
endinterface

// File: rtl/xmem_pair_sched.sv
// xmem_pair_sched: loads N point words into the dual-port memory, then streams every point pair to the distance pipeline.
// Ports:
//   CLK, RESET      clock (rising edge), synchronous active-high reset
//   start, num_pts  begin a run with N points (sampled only when idle)
//   busy, done      run in progress / one-cycle end-of-run pulse
//   bus (master)    load stream, pair stream and memory pins, see xmem_pair_sched_if
// Option: define XMEM_SELF_PAIR_EN to also emit self pairs (i,i).
module xmem_pair_sched #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [ADDR_W:0] num_pts,
    output logic            busy,
    output logic            done,
    xmem_pair_sched_if.master bus
);
    // One extra bit so that N=DEPTH and the one-past-last pair index are representable.
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);
`ifdef XMEM_SELF_PAIR_EN
    localparam logic [CW-1:0] J_OFF = '0;
`else
    localparam logic [CW-1:0] J_OFF = ONE;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, PAIR, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     load_cnt_q, load_cnt_d;
    logic [CW-1:0]     i_q, i_d;
    logic [CW-1:0]     j_q, j_d;
    logic [ADDR_W-1:0] out_i_q, out_i_d;
    logic [ADDR_W-1:0] out_j_q, out_j_d;
    logic              out_valid_q, out_valid_d;
    logic              pairs_left;
    logic              issue;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            n_q         <= '0;
            load_cnt_q  <= '0;
            i_q         <= '0;
            j_q         <= '0;
            out_i_q     <= '0;
            out_j_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            load_cnt_q  <= load_cnt_d;
            i_q         <= i_d;
            j_q         <= j_d;
            out_i_q     <= out_i_d;
            out_j_q     <= out_j_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        load_cnt_d   = load_cnt_q;
        i_d          = i_q;
        j_d          = j_q;
        out_i_d      = out_i_q;
        out_j_d      = out_j_q;
        out_valid_d  = out_valid_q;
        bus.in_ready = 1'b0;
        bus.mem_cen0 = 1'b1;
        bus.mem_wen0 = 1'b1;
        bus.mem_a0   = '0;
        bus.mem_d0   = '0;
        bus.mem_cen1 = 1'b1;
        bus.mem_wen1 = 1'b1;
        bus.mem_a1   = '0;
        // j walks past N-1 exactly when the pair list is exhausted.
        pairs_left   = j_q < n_q;
        issue        = 1'b0;
        busy         = state_q == LOAD || state_q == PAIR;
        done         = state_q == DONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d        = num_pts;
                    load_cnt_d = '0;
                    i_d        = '0;
                    j_d        = J_OFF;
                    state_d    = num_pts == '0 ? DONE : LOAD;
                end
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.mem_cen0 = 1'b0;
                    bus.mem_wen0 = 1'b0;
                    bus.mem_a0   = load_cnt_q[ADDR_W-1:0];
                    bus.mem_d0   = bus.in_data;
                    load_cnt_d   = load_cnt_q + ONE;
                    // Too few points to form any pair: skip PAIR entirely.
                    if (load_cnt_d == n_q)
                        state_d = n_q > J_OFF ? PAIR : DONE;
                end
            end
            PAIR: begin
                // The output slot frees when empty or being accepted this cycle.
                issue = pairs_left && (!out_valid_q || bus.out_ready);
                if (issue) begin
                    bus.mem_cen0 = 1'b0;
                    bus.mem_cen1 = 1'b0;
                    bus.mem_a0   = i_q[ADDR_W-1:0];
                    bus.mem_a1   = j_q[ADDR_W-1:0];
                    out_i_d      = i_q[ADDR_W-1:0];
                    out_j_d      = j_q[ADDR_W-1:0];
                    out_valid_d  = 1'b1;
                    i_d          = j_q + ONE == n_q ? i_q + ONE : i_q;
                    j_d          = j_q + ONE == n_q ? i_q + ONE + J_OFF : j_q + ONE;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (out_valid_q && bus.out_ready && !pairs_left)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data is passed straight through; a stalled memory holds its last read.
    assign bus.out_i     = out_i_q;
    assign bus.out_j     = out_j_q;
    assign bus.out_q0    = bus.mem_q0;
    assign bus.out_q1    = bus.mem_q1;
    assign bus.out_valid = out_valid_q;
    assign bus.mem_d1    = '0;
endmodule
